sc_mult_scheduler: RTL and testbench
====================================

Name: sc_mult_scheduler

Overview:
- Sequences one shared stochastic bipolar multiplier datapath (two 31-bit LFSRs, 4-bit comparators, XNOR) between NREQ requesters.
- For each request it arbitrates round-robin, loads LFSR seeds and operands, and runs a window of 2^WIN_LOG2 stochastic bits.
- It counts the returned SN bits, compensating for datapath pipeline latency, and returns a non-overflowing count to the winning requester.
- It sits between the requester logic and the stochastic datapath; it does not generate any random bits itself.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIN_LOG2, 7: log2 of the evaluation window length in bitstream cycles.
- PIPE_LAT, 2: cycles from a dp_en=1 cycle to the corresponding dp_sn_bit (1..4).
- SEED_A, 31'd1: seed loaded into LFSR A every job.
- SEED_B, 31'd2: seed loaded into LFSR B every job.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high (rst_n=1 resets).
- req  in  NREQ  per-requester request level.
- opa  in  4*NREQ  operand A of requester i at [4i+3:4i].
- opb  in  4*NREQ  operand B of requester i at [4i+3:4i].
- gnt  out  NREQ  one-hot grant, held for the job.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  clog2(NREQ)  index of the completed requester; valid while done=1.
- result  out  WIN_LOG2+1  count of ones in the window; valid while done=1, held until the next done.
- dp_load  out  1  datapath seed/operand load strobe.
- dp_seed_a  out  31  equals SEED_A.
- dp_seed_b  out  31  equals SEED_B.
- dp_opa  out  4  latched operand A.
- dp_opb  out  4  latched operand B.
- dp_en  out  1  datapath advance enable.
- dp_sn_bit  in  1  XNOR product bit from the datapath.

Behaviour:
- Reset (async, rst_n=1):
  - state=IDLE.
  - gnt, busy, done, done_id, result, dp_load, dp_en, dp_opa, dp_opb all 0.
  - Valid pipe and counters cleared.
  - Reset mid-job abandons the job; no done is issued.
- FSM: IDLE -> LOAD -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward (with wrap) from last_id+1. last_id resets to NREQ-1, so requester 0 is first after reset.
  - Register gnt one-hot, latch that requester's opa/opb into dp_opa/dp_opb, then go to LOAD.
- LOAD (1 cycle): dp_load=1, dp_en=0, ones counter cleared.
- RUN:
  - Exactly 2^WIN_LOG2 cycles with dp_en=1, counted by a WIN_LOG2+1-bit cycle counter.
- DRAIN:
  - PIPE_LAT cycles with dp_en=0.
- Sampling:
  - A PIPE_LAT-deep valid shift register is fed by dp_en.
  - dp_sn_bit is accumulated only when the register's last stage is 1.
  - This gives exactly 2^WIN_LOG2 samples per job.
- Ones counter is WIN_LOG2+1 bits wide. An all-ones window gives 2^WIN_LOG2 (128 by default); no wrap and no overflow flag.
- DONE (1 cycle):
  - done=1; done_id = granted index; result = ones count; last_id updated; gnt=0.
- gnt and busy are high from LOAD through DRAIN. busy is also high in DONE.
- Latency:
  - gnt rises at edge E; done is high during the cycle starting at E+1+2^WIN_LOG2+PIPE_LAT.
  - Default: 131 cycles after gnt rises.
  - Next grant is issued on the edge after DONE.
- Request rules:
  - req and operands are sampled only in IDLE. Changes during a job are ignored.
  - A requester that drops req mid-job still receives its done.
  - Requesters must drop req in the done cycle if they want no further job.
- Operand 0 encodes probability 0; operand 15 encodes 15/16 (comparator semantics: LFSR nibble < operand).

Test Plan:
- dp_sn_bit tied 1, req=4'b0001 -> gnt=4'b0001 for 131 cycles (LOAD+RUN+DRAIN); done at gnt+131; result=128; done_id=0.
- dp_sn_bit tied 0 -> result=0; exactly one done pulse; gnt drops in the DONE cycle.
- req=4'b1111 held continuously -> done_id sequence 0,1,2,3,0; one idle cycle between DONE and the next gnt.
- Bench drives dp_sn_bit=1 only on the first PIPE_LAT valid-sample cycles and 0 afterwards -> result=2, proving latency alignment and that pre-RUN bits are ignored.
- Behavioural datapath model with opa=opb=4'hF, run twice -> identical results both times (seeds reloaded); dp_load high exactly one cycle per job; dp_en high exactly 128 cycles per job.
- rst_n pulsed at RUN cycle 50 -> all outputs 0 immediately; no done; next req=4'b0100 -> grant to requester 2, then normal completion.

Source files
------------

// File: rtl/sc_mult_scheduler.sv
// Round-robin scheduler for one shared stochastic bipolar multiplier datapath.
// Each job loads seeds/operands, runs a 2^WIN_LOG2-bit window and returns the ones count.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches operands
// LOAD  | one-cycle seed/operand load strobe; ones count cleared
// RUN   | 2^WIN_LOG2 cycles with dp_en=1
// DRAIN | PIPE_LAT cycles for the last product bits to return
// DONE  | one-cycle completion pulse with done_id/result
module sc_mult_scheduler #(
    parameter int          NREQ     = 4,
    parameter int          WIN_LOG2 = 7,
    parameter int          PIPE_LAT = 2,
    parameter logic [30:0] SEED_A   = 31'd1,
    parameter logic [30:0] SEED_B   = 31'd2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [4*NREQ-1:0]       opa,
    input  logic [4*NREQ-1:0]       opb,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [WIN_LOG2:0]       result,
    output logic                    dp_load,
    output logic [30:0]             dp_seed_a,
    output logic [30:0]             dp_seed_b,
    output logic [3:0]              dp_opa,
    output logic [3:0]              dp_opb,
    output logic                    dp_en,
    input  logic                    dp_sn_bit
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0] RUN_TC_LOAD   = CNT_W'((1 << WIN_LOG2) - 1);
    localparam logic [CNT_W-1:0] DRAIN_TC_LOAD = CNT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    tmr;
    logic [CNT_W-1:0]    tmr_nxt;
    logic [CNT_W-1:0]    ones;
    logic [CNT_W-1:0]    ones_nxt;
    logic [PIPE_LAT-1:0] vld_pipe;
    logic [ID_W-1:0]     last_id;
    logic [ID_W-1:0]     gnt_id;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W-1:0]     scan_id;
    logic                pick_vld;

    assign dp_seed_a = SEED_A;
    assign dp_seed_b = SEED_B;

    // Scan downward in distance so the requester nearest after last_id wins.
    always_comb begin : arb
        pick_vld = 1'b0;
        pick_id  = '0;
        scan_id  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            scan_id = ID_W'((int'(last_id) + i) % NREQ);
            if (req[scan_id]) begin
                pick_vld = 1'b1;
                pick_id  = scan_id;
            end
        end
    end

    // The last stage of the valid pipe lines up with the product of a dp_en cycle.
    assign ones_nxt = ones + CNT_W'(vld_pipe[PIPE_LAT-1] & dp_sn_bit);

    always_comb begin : fsm_nxt
        state_nxt = state;
        tmr_nxt   = tmr;
        busy      = 1'b1;
        done      = 1'b0;
        dp_load   = 1'b0;
        dp_en     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (pick_vld) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                dp_load   = 1'b1;
                tmr_nxt   = RUN_TC_LOAD;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                dp_en = 1'b1;
                if (tmr == '0) begin
                    tmr_nxt   = DRAIN_TC_LOAD;
                    state_nxt = S_DRAIN;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            S_DRAIN: begin
                if (tmr == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= S_IDLE;
            tmr      <= '0;
            ones     <= '0;
            vld_pipe <= '0;
            last_id  <= ID_W'(NREQ - 1);
            gnt_id   <= '0;
            gnt      <= '0;
            done_id  <= '0;
            result   <= '0;
            dp_opa   <= '0;
            dp_opb   <= '0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            vld_pipe <= (vld_pipe << 1) | PIPE_LAT'(dp_en);
            ones     <= (state == S_LOAD) ? '0 : ones_nxt;
            if (state == S_IDLE && pick_vld) begin
                gnt    <= NREQ'(1) << pick_id;
                gnt_id <= pick_id;
                dp_opa <= opa[4*pick_id +: 4];
                dp_opb <= opb[4*pick_id +: 4];
            end
            // ones_nxt already includes the final sample returning in the last DRAIN cycle.
            if (state == S_DRAIN && state_nxt == S_DONE) begin
                gnt     <= '0;
                done_id <= gnt_id;
                result  <= ones_nxt;
            end
            if (state == S_DONE) begin
                last_id <= gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_sc_mult_scheduler.sv
// Self-checking bench for sc_mult_scheduler: job-level reference model, datapath model,
// directed scenarios with literal expectations, then a randomized request phase.
module tb_sc_mult_scheduler;

    localparam int          NREQ     = 4;
    localparam int          WIN_LOG2 = 7;
    localparam int          PIPE_LAT = 2;
    localparam int          WIN      = 1 << WIN_LOG2;
    localparam logic [30:0] SEED_A   = 31'd1;
    localparam logic [30:0] SEED_B   = 31'd2;
    localparam int          DONE_OFF = WIN + PIPE_LAT + 1;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] opa;
    logic [4*NREQ-1:0] opb;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic [1:0]        done_id;
    logic [WIN_LOG2:0] result;
    logic              dp_load;
    logic [30:0]       dp_seed_a;
    logic [30:0]       dp_seed_b;
    logic [3:0]        dp_opa;
    logic [3:0]        dp_opb;
    logic              dp_en;
    logic              dp_sn_bit;

    sc_mult_scheduler #(
        .NREQ(NREQ), .WIN_LOG2(WIN_LOG2), .PIPE_LAT(PIPE_LAT),
        .SEED_A(SEED_A), .SEED_B(SEED_B)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .opa(opa), .opb(opb),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .result(result),
        .dp_load(dp_load), .dp_seed_a(dp_seed_a), .dp_seed_b(dp_seed_b),
        .dp_opa(dp_opa), .dp_opb(dp_opb), .dp_en(dp_en), .dp_sn_bit(dp_sn_bit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int sn_mode = 0;   // 0 tied 0, 1 tied 1, 2 first valid samples only, 3 datapath model, 4 random

    // model state
    bit         m_act = 0;
    int         m_g = 0;
    int         m_w = 0;
    int         m_last = NREQ - 1;
    int         m_res = 0;
    logic [3:0] m_opa = '0;
    logic [3:0] m_opb = '0;
    bit         sn_hist [0:65535];

    // datapath model state
    logic [30:0]         la;
    logic [30:0]         lb;
    logic [PIPE_LAT-1:0] dpq;

    // observed events
    int gnt_rise_q[$];
    int done_cyc_q[$];
    int done_id_q[$];
    int done_res_q[$];
    int ld_q[$];
    int en_q[$];
    int ld_cnt = 0;
    int en_cnt = 0;
    logic [NREQ-1:0] prev_gnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            if (r[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    // Reference model, datapath model and per-cycle compare, all at the falling edge.
    initial begin : model
        int   off;
        bit   sn;
        bit   sn_out;
        bit   pa;
        bit   pb;
        bit   e_done;
        logic [NREQ-1:0] e_gnt;
        dp_sn_bit = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                m_act = 0; m_last = NREQ - 1; m_res = 0;
                ld_cnt = 0; en_cnt = 0; prev_gnt = '0;
                la = SEED_A; lb = SEED_B; dpq = '0;
                chk("rst_gnt", gnt, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_done_id", done_id, 0);
                chk("rst_result", result, 0);
                chk("rst_dp_load", dp_load, 0);
                chk("rst_dp_en", dp_en, 0);
                chk("rst_dp_opa", dp_opa, 0);
                chk("rst_dp_opb", dp_opb, 0);
                chk("seed_a", dp_seed_a, SEED_A);
                chk("seed_b", dp_seed_b, SEED_B);
                dp_sn_bit = 1'b0;
                sn_hist[cyc] = 1'b0;
            end else begin
                off    = m_act ? cyc - m_g : -1;
                e_done = m_act && off == DONE_OFF;
                e_gnt  = (m_act && !e_done) ? NREQ'(1 << m_w) : '0;
                if (e_done) begin
                    m_res = 0;
                    for (int k = m_g + 1 + PIPE_LAT; k <= m_g + WIN + PIPE_LAT; k++)
                        m_res += int'(sn_hist[k]);
                end
                chk("gnt", gnt, e_gnt);
                chk("busy", busy, m_act);
                chk("done", done, e_done);
                chk("dp_load", dp_load, m_act && off == 0);
                chk("dp_en", dp_en, m_act && off >= 1 && off <= WIN);
                chk("result", result, m_res);
                if (e_done) chk("done_id", done_id, m_w);
                if (m_act) begin
                    chk("dp_opa", dp_opa, m_opa);
                    chk("dp_opb", dp_opb, m_opb);
                end

                if (gnt != 0 && prev_gnt == 0) gnt_rise_q.push_back(cyc);
                prev_gnt = gnt;
                if (dp_load) ld_cnt++;
                if (dp_en) en_cnt++;
                if (done) begin
                    done_cyc_q.push_back(cyc);
                    done_id_q.push_back(int'(done_id));
                    done_res_q.push_back(int'(result));
                    ld_q.push_back(ld_cnt);
                    en_q.push_back(en_cnt);
                    ld_cnt = 0;
                    en_cnt = 0;
                end

                // datapath: comparators on LFSR nibbles, XNOR, PIPE_LAT-cycle delay
                sn_out = dpq[PIPE_LAT-1];
                pa = la[3:0] < dp_opa;
                pb = lb[3:0] < dp_opb;
                dpq = (dpq << 1) | PIPE_LAT'(dp_en & ~(pa ^ pb));
                if (dp_load) begin
                    la = SEED_A;
                    lb = SEED_B;
                end else if (dp_en) begin
                    la = {la[29:0], la[30] ^ la[27]};
                    lb = {lb[29:0], lb[30] ^ lb[27]};
                end

                case (sn_mode)
                    0:       sn = 1'b0;
                    1:       sn = 1'b1;
                    2:       sn = !m_act || off <= 2 * PIPE_LAT;
                    3:       sn = sn_out;
                    default: sn = 1'($urandom_range(0, 1));
                endcase
                dp_sn_bit = sn;
                sn_hist[cyc] = sn;

                if (e_done) begin
                    m_act  = 0;
                    m_last = m_w;
                end else if (!m_act && req != 0) begin
                    m_w   = pick(req, m_last);
                    m_act = 1;
                    m_g   = cyc + 1;
                    m_opa = opa[4*m_w +: 4];
                    m_opb = opb[4*m_w +: 4];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int n, input int budget);
        int k = 0;
        while (gnt_rise_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_gnt_in_time", gnt_rise_q.size() >= n, 1);
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cyc_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_done_in_time", done_cyc_q.size() >= n, 1);
    endtask

    // Requester drops req right after the grant; the job must still complete.
    task automatic run_one(input logic [NREQ-1:0] r, input int mode);
        int ng = gnt_rise_q.size();
        int nd = done_cyc_q.size();
        sn_mode = mode;
        req = r;
        wait_gnt(ng + 1, 10);
        req = '0;
        wait_done(nd + 1, 200);
        tick();
        tick();
    endtask

    initial begin : stim
        int base;
        int gbase;
        int r1;
        int nd;
        int exp_ids [5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b1;
        req = '0;
        opa = '0;
        opb = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();

        // all-ones window from requester 0
        opa = 16'h3A5C;
        opb = 16'h71E2;
        run_one(4'b0001, 1);
        chk("t1_result", done_res_q[$], 128);
        chk("t1_done_id", done_id_q[$], 0);
        chk("t1_latency", done_cyc_q[$] - gnt_rise_q[$], 131);
        chk("t1_load_cycles", ld_q[$], 1);
        chk("t1_en_cycles", en_q[$], 128);

        // all-zeros window, single done pulse
        nd = done_cyc_q.size();
        run_one(4'b1000, 0);
        chk("t2_result", done_res_q[$], 0);
        chk("t2_done_id", done_id_q[$], 3);
        repeat (140) tick();
        chk("t2_one_done", done_cyc_q.size(), nd + 1);

        // all requesting continuously
        sn_mode = 4;
        base = done_cyc_q.size();
        gbase = gnt_rise_q.size();
        req = 4'b1111;
        begin
            int k = 0;
            while (done_cyc_q.size() < base + 5 && k < 5 * 140) begin
                tick();
                k++;
            end
        end
        req = '0;
        chk("t3_five_dones", done_cyc_q.size() >= base + 5, 1);
        if (done_cyc_q.size() >= base + 5 && gnt_rise_q.size() >= gbase + 5) begin
            for (int k = 0; k < 5; k++) chk("t3_done_id_seq", done_id_q[base+k], exp_ids[k]);
            for (int k = 0; k < 4; k++)
                chk("t3_idle_gap", gnt_rise_q[gbase+k+1] - done_cyc_q[base+k], 2);
        end
        repeat (3) tick();

        // only the first PIPE_LAT valid samples carry a one; pre-run ones ignored
        run_one(4'b0100, 2);
        chk("t4_result", done_res_q[$], 2);
        chk("t4_done_id", done_id_q[$], 2);

        // datapath model, same operands twice
        opa = 16'hFFFF;
        opb = 16'hFFFF;
        run_one(4'b0001, 3);
        r1 = done_res_q[$];
        chk("t5_load_cycles_1", ld_q[$], 1);
        chk("t5_en_cycles_1", en_q[$], 128);
        run_one(4'b0001, 3);
        chk("t5_repeatable", done_res_q[$], r1);
        chk("t5_load_cycles_2", ld_q[$], 1);
        chk("t5_en_cycles_2", en_q[$], 128);

        // reset in the middle of RUN
        sn_mode = 1;
        gbase = gnt_rise_q.size();
        req = 4'b0001;
        wait_gnt(gbase + 1, 10);
        req = '0;
        repeat (49) tick();
        rst_n = 1'b1;
        #1;
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_dp_en", dp_en, 0);
        chk("t6_rst_result", result, 0);
        tick();
        tick();
        rst_n = 1'b0;
        nd = done_cyc_q.size();
        repeat (150) tick();
        chk("t6_no_done", done_cyc_q.size(), nd);
        run_one(4'b0100, 1);
        chk("t6_done_id", done_id_q[$], 2);
        chk("t6_result", done_res_q[$], 128);

        // randomized requests, operands and product bits
        base = done_cyc_q.size();
        for (int it = 0; it < 2000; it++) begin
            if ($urandom_range(0, 15) == 0) req = NREQ'($urandom);
            if ($urandom_range(0, 199) == 0) sn_mode = $urandom_range(0, 4);
            opa = 16'($urandom);
            opb = 16'($urandom);
            tick();
        end
        req = '0;
        begin
            int k = 0;
            while (busy && k < 300) begin
                tick();
                k++;
            end
        end
        tick();
        chk("rand_idle_at_end", busy, 0);
        chk("rand_jobs_completed", done_cyc_q.size() >= base + 5, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
